// File: rtl/motor_code_sched_if.sv
// Command handshake between the flight-loop register bank and the motor frame scheduler.
// master drives the command vector; slave (the scheduler) returns CMD_READY.
interface motor_code_sched_if #(
  parameter int unsigned NCH = 4
) ();
  logic [16*NCH-1:0] CMD_CODE;
  logic              CMD_VALID;
  logic              CMD_READY;

  modport master (output CMD_CODE, output CMD_VALID, input CMD_READY);
  modport slave  (input CMD_CODE, input CMD_VALID, output CMD_READY);
endinterface

// File: rtl/motor_code_sched.sv
// Frame scheduler / arming controller for NCH code-to-pulse generator channels.
// Optional per-frame slew limiting is enabled by defining MOTOR_RAMP_EN.
module motor_code_sched #(
  parameter int unsigned NCH            = 4,
  parameter int unsigned CNT_W          = 16,
  parameter logic [15:0] MIN_CODE       = 16'd1000,
  parameter logic [15:0] MAX_CODE       = 16'd2000,
  parameter int unsigned ARM_FRAMES     = 16,
  parameter int unsigned TIMEOUT_FRAMES = 8,
  parameter logic [15:0] MAX_STEP       = 16'd50
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ARM,
  motor_code_sched_if.slave   cmd,
  output logic [16*NCH-1:0]   CODE,
  output logic [NCH-1:0]      VALID,
  output logic [1:0]          STATE
);

  typedef enum logic [1:0] {
    StDisarmed = 2'd0,
    StArming   = 2'd1,
    StArmed    = 2'd2,
    StFailsafe = 2'd3
  } state_e;

  localparam int unsigned     ArmW   = $clog2(ARM_FRAMES + 1);
  localparam int unsigned     ToW    = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CNT_W-1:0] UpdCnt = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [16*NCH-1:0] MinVec = {NCH{MIN_CODE}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [16*NCH-1:0]   code_q, code_d;
  logic [NCH-1:0]      valid_q;
  logic                pend_q, pend_d;
  logic [16*NCH-1:0]   pend_code_q, pend_code_d;
  logic [ArmW-1:0]     arm_cnt_q, arm_cnt_d, arm_cnt_inc;
  logic [ToW-1:0]      to_cnt_q, to_cnt_d, to_cnt_inc;
  logic                upd, arm_last, to_last;
`ifdef MOTOR_RAMP_EN
  logic [16*NCH-1:0]   tgt_q, tgt_d;
  logic                slewing;
`endif

  function automatic logic [15:0] clamp(input logic [15:0] v);
    if (v < MIN_CODE)      return MIN_CODE;
    else if (v > MAX_CODE) return MAX_CODE;
    else                   return v;
  endfunction

  function automatic logic [16*NCH-1:0] clamp_vec(input logic [16*NCH-1:0] v);
    logic [16*NCH-1:0] r;
    for (int i = 0; i < int'(NCH); i++) r[16*i +: 16] = clamp(v[16*i +: 16]);
    return r;
  endfunction

  function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] tgt);
    if (tgt > cur) return ((tgt - cur) > MAX_STEP) ? cur + MAX_STEP : tgt;
    else           return ((cur - tgt) > MAX_STEP) ? cur - MAX_STEP : tgt;
  endfunction

  function automatic logic [16*NCH-1:0] slew_vec(input logic [16*NCH-1:0] cur,
                                                 input logic [16*NCH-1:0] tgt);
    logic [16*NCH-1:0] r;
    for (int i = 0; i < int'(NCH); i++) r[16*i +: 16] = slew(cur[16*i +: 16], tgt[16*i +: 16]);
    return r;
  endfunction

  // One cycle ahead of the generator wrap, so the new code lands on cnt == all-ones.
  assign upd           = (cnt_q == UpdCnt);
  assign cmd.CMD_READY = ~upd;

  assign arm_cnt_inc = (32'(arm_cnt_q) >= ARM_FRAMES) ? arm_cnt_q : arm_cnt_q + 1'b1;
  assign arm_last    = (32'(arm_cnt_inc) >= ARM_FRAMES);
  assign to_cnt_inc  = (32'(to_cnt_q) >= TIMEOUT_FRAMES) ? to_cnt_q : to_cnt_q + 1'b1;
  assign to_last     = (32'(to_cnt_inc) >= TIMEOUT_FRAMES);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= StDisarmed;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!ARM) begin
      state_d = StDisarmed;
    end else begin
      unique case (state_q)
        StDisarmed: state_d = StArming;
        StArming:   if (upd && arm_last) state_d = StArmed;
        StArmed:    if (upd && !pend_q && to_last) state_d = StFailsafe;
        StFailsafe: if (upd && pend_q) state_d = StArmed;
        default:    state_d = StDisarmed;
      endcase
    end
  end

  // Code selection, pending buffer and frame counters
  always_comb begin
    code_d      = code_q;
    pend_d      = pend_q;
    pend_code_d = pend_code_q;
    arm_cnt_d   = arm_cnt_q;
    to_cnt_d    = to_cnt_q;
`ifdef MOTOR_RAMP_EN
    tgt_d       = tgt_q;
    slewing     = 1'b0;
`endif
    if (cmd.CMD_VALID && cmd.CMD_READY) begin
      pend_d      = 1'b1;
      pend_code_d = cmd.CMD_CODE;
    end
    if (upd) begin
      if (!ARM) begin
        code_d = '0;
      end else begin
        unique case (state_q)
          StDisarmed: code_d = '0;
          StArming: begin
            code_d    = MinVec;
            arm_cnt_d = arm_cnt_inc;
            if (arm_last) begin
              pend_d   = 1'b0;
              to_cnt_d = '0;
            end
          end
          StArmed, StFailsafe: begin
            if (pend_q) begin
`ifdef MOTOR_RAMP_EN
              tgt_d   = clamp_vec(pend_code_q);
              code_d  = slew_vec(code_q, tgt_d);
              slewing = 1'b1;
`else
              code_d  = clamp_vec(pend_code_q);
`endif
              pend_d   = 1'b0;
              to_cnt_d = '0;
            end else if (state_q == StFailsafe || to_last) begin
              code_d   = MinVec;
              to_cnt_d = to_cnt_inc;
            end else begin
              to_cnt_d = to_cnt_inc;
`ifdef MOTOR_RAMP_EN
              code_d  = slew_vec(code_q, tgt_q);
              slewing = 1'b1;
`endif
            end
          end
          default: code_d = '0;
        endcase
      end
`ifdef MOTOR_RAMP_EN
      // Unslewed applications become the new resting target.
      if (!slewing) tgt_d = code_d;
`endif
    end
    if (state_d == StDisarmed) begin
      pend_d    = 1'b0;
      arm_cnt_d = '0;
      to_cnt_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      code_q      <= '0;
      valid_q     <= '0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      arm_cnt_q   <= '0;
      to_cnt_q    <= '0;
`ifdef MOTOR_RAMP_EN
      tgt_q       <= '0;
`endif
    end else begin
      cnt_q       <= cnt_q + 1'b1;
      valid_q     <= {NCH{upd}};
      code_q      <= code_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      arm_cnt_q   <= arm_cnt_d;
      to_cnt_q    <= to_cnt_d;
`ifdef MOTOR_RAMP_EN
      tgt_q       <= tgt_d;
`endif
    end
  end

  assign CODE  = code_q;
  assign VALID = valid_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_motor_code_sched.sv
// Directed bench for motor_code_sched: frame-level vector table plus handshake/reset corner cases.
module tb_motor_code_sched;
  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              ARM;
  logic [16*NCH-1:0] CODE;
  logic [NCH-1:0]    VALID;
  logic [1:0]        STATE;

  motor_code_sched_if #(.NCH(NCH)) cmd_if ();

  motor_code_sched #(
    .NCH(NCH), .CNT_W(CNT_W), .MIN_CODE(16'd1000), .MAX_CODE(16'd2000),
    .ARM_FRAMES(2), .TIMEOUT_FRAMES(3), .MAX_STEP(16'd50)
  ) dut (
    .CLK(CLK), .RST(RST), .ARM(ARM), .cmd(cmd_if), .CODE(CODE), .VALID(VALID), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Independent model of the frame position.
  logic [CNT_W-1:0] tb_cnt;
  always @(posedge CLK) begin
    if (RST) tb_cnt <= '0;
    else     tb_cnt <= tb_cnt + 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          arm;
    bit          send;
    logic [63:0] cmd;
    logic [1:0]  st;
    logic [63:0] code;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  function automatic logic [63:0] chan4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (VALID != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_valid_seen"}, 64'(ok), 64'd1);
    check({name, "_valid_all"}, 64'(VALID), 64'hF);
  endtask

  task automatic wait_cnt(input logic [CNT_W-1:0] target);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (tb_cnt == target) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_cnt", 64'(ok), 64'd1);
  endtask

  task automatic send_cmd(input logic [63:0] c);
    bit ok = 1'b0;
    cmd_if.CMD_CODE  = c;
    cmd_if.CMD_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_if.CMD_READY) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("ready_seen", 64'(ok), 64'd1);
    @(negedge CLK);
    cmd_if.CMD_VALID = 1'b0;
  endtask

  task automatic span_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("valid_phase", 64'(VALID), (tb_cnt == 4'd15) ? 64'hF : 64'h0);
      check("ready_phase", 64'(cmd_if.CMD_READY), (tb_cnt == 4'd14) ? 64'd0 : 64'd1);
    end
  endtask

  initial begin
    RST              = 1'b1;
    ARM              = 1'b0;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_CODE  = '0;

    // Frame-level vectors; each is applied at a VALID cycle and checked at the next VALID.
    tbl[0]  = '{1'b1, 1'b0, 64'd0, 2'd1, rep(16'd1000)};
    tbl[1]  = '{1'b1, 1'b0, 64'd0, 2'd2, rep(16'd1000)};
    tbl[2]  = '{1'b1, 1'b1, chan4(16'd500, 16'd1500, 16'd2500, 16'd1200), 2'd2,
                chan4(16'd1000, 16'd1500, 16'd2000, 16'd1200)};
    tbl[3]  = '{1'b1, 1'b0, 64'd0, 2'd2, chan4(16'd1000, 16'd1500, 16'd2000, 16'd1200)};
    tbl[4]  = '{1'b1, 1'b0, 64'd0, 2'd2, chan4(16'd1000, 16'd1500, 16'd2000, 16'd1200)};
    tbl[5]  = '{1'b1, 1'b0, 64'd0, 2'd3, rep(16'd1000)};
    tbl[6]  = '{1'b1, 1'b0, 64'd0, 2'd3, rep(16'd1000)};
`ifdef MOTOR_RAMP_EN
    tbl[7]  = '{1'b1, 1'b1, rep(16'd1300), 2'd2, rep(16'd1050)};
`else
    tbl[7]  = '{1'b1, 1'b1, rep(16'd1300), 2'd2, rep(16'd1300)};
`endif
    tbl[8]  = '{1'b0, 1'b0, 64'd0, 2'd0, rep(16'd0)};
    tbl[9]  = '{1'b1, 1'b0, 64'd0, 2'd1, rep(16'd1000)};
    tbl[10] = '{1'b1, 1'b0, 64'd0, 2'd2, rep(16'd1000)};
`ifdef MOTOR_RAMP_EN
    tbl[11] = '{1'b1, 1'b1, rep(16'd1200), 2'd2, rep(16'd1050)};
    tbl[12] = '{1'b1, 1'b1, rep(16'd1200), 2'd2, rep(16'd1100)};
    tbl[13] = '{1'b1, 1'b0, 64'd0, 2'd2, rep(16'd1150)};
`else
    tbl[11] = '{1'b1, 1'b1, rep(16'd1200), 2'd2, rep(16'd1200)};
    tbl[12] = '{1'b1, 1'b1, rep(16'd1200), 2'd2, rep(16'd1200)};
    tbl[13] = '{1'b1, 1'b0, 64'd0, 2'd2, rep(16'd1200)};
`endif
    tbl[14] = '{1'b1, 1'b0, 64'd0, 2'd2, rep(16'd1200)};

    // Reset state and frame phase of VALID / CMD_READY
    repeat (3) @(negedge CLK);
    check("rst_code", CODE, 64'd0);
    check("rst_valid", 64'(VALID), 64'd0);
    check("rst_state", 64'(STATE), 64'd0);
    RST = 1'b0;
    span_check(40);
    wait_valid("align");
    check("align_code", CODE, 64'd0);
    check("align_state", 64'(STATE), 64'd0);

    for (int i = 0; i < 15; i++) begin
      ARM = tbl[i].arm;
      if (tbl[i].send) send_cmd(tbl[i].cmd);
      wait_valid($sformatf("vec%0d", i));
      check($sformatf("vec%0d_state", i), 64'(STATE), 64'(tbl[i].st));
      check($sformatf("vec%0d_code", i), CODE, tbl[i].code);
    end

    // Two transfers in one frame: the later one wins.
    cmd_if.CMD_CODE  = rep(16'd1100);
    cmd_if.CMD_VALID = 1'b1;
    @(negedge CLK);
    cmd_if.CMD_CODE  = rep(16'd1230);
    @(negedge CLK);
    cmd_if.CMD_VALID = 1'b0;
    wait_valid("latest");
    check("latest_code", CODE, rep(16'd1230));
    check("latest_state", 64'(STATE), 64'd2);

    // Offered on the UPD cycle: held off, accepted one cycle later, applied next frame.
    wait_cnt(4'd14);
    cmd_if.CMD_CODE  = rep(16'd1210);
    cmd_if.CMD_VALID = 1'b1;
    check("upd_ready_low", 64'(cmd_if.CMD_READY), 64'd0);
    @(negedge CLK);
    check("wrap_ready_high", 64'(cmd_if.CMD_READY), 64'd1);
    check("wrap_valid", 64'(VALID), 64'hF);
    check("wrap_code_held", CODE, rep(16'd1230));
    @(negedge CLK);
    cmd_if.CMD_VALID = 1'b0;
    wait_valid("late");
    check("late_code", CODE, rep(16'd1210));
    check("late_state", 64'(STATE), 64'd2);

    // ARM dropped mid-frame: state follows at once, code at the next VALID.
    wait_cnt(4'd5);
    ARM = 1'b0;
    @(negedge CLK);
    check("disarm_state", 64'(STATE), 64'd0);
    check("disarm_code_kept", CODE, rep(16'd1210));
    wait_valid("disarm");
    check("disarm_code", CODE, 64'd0);
    check("disarm_state_v", 64'(STATE), 64'd0);

    // Re-arm, then reset mid-frame with a command offered in the same cycle.
    ARM = 1'b1;
    wait_valid("rearm");
    check("rearm_state", 64'(STATE), 64'd1);
    check("rearm_code", CODE, rep(16'd1000));
    wait_cnt(4'd6);
    RST              = 1'b1;
    ARM              = 1'b0;
    cmd_if.CMD_CODE  = rep(16'd1900);
    cmd_if.CMD_VALID = 1'b1;
    @(negedge CLK);
    check("mrst_code", CODE, 64'd0);
    check("mrst_valid", 64'(VALID), 64'd0);
    check("mrst_state", 64'(STATE), 64'd0);
    check("mrst_ready", 64'(cmd_if.CMD_READY), 64'd1);
    RST              = 1'b0;
    cmd_if.CMD_VALID = 1'b0;
    span_check(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
